// File: rtl/id_stage_pkg.sv
// Shared decode constants for the MIPS ID stage.
// Also defines the packed control bundle used between decoder and stage.
package id_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic       branch_ne;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/id_ctrl.sv
// Main control decoder: opcode/funct to datapath controls.
// Anything not recognised decodes to all-zero controls (a NOP).
module id_ctrl
  import id_stage_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic       reg_write_o,
  output logic       mem_to_reg_o,
  output logic       mem_write_o,
  output logic       alu_src_o,
  output logic       reg_dst_o,
  output logic       branch_o,
  output logic       branch_ne_o,
  output logic [2:0] alu_ctrl_o
);

  ctrl_t c;

  always_comb begin
    c = CTRL_NOP;
    case (op_i)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        case (funct_i)
          FN_ADD:  c.alu_ctrl = ALU_ADD;
          FN_SUB:  c.alu_ctrl = ALU_SUB;
          FN_AND:  c.alu_ctrl = ALU_AND;
          FN_OR:   c.alu_ctrl = ALU_OR;
          FN_SLT:  c.alu_ctrl = ALU_SLT;
          default: c = CTRL_NOP;
        endcase
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
        c.alu_ctrl   = ALU_ADD;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_ctrl  = ALU_ADD;
      end
      OP_BEQ: begin
        c.branch   = 1'b1;
        c.alu_ctrl = ALU_SUB;
      end
      OP_BNE: begin
        c.branch    = 1'b1;
        c.branch_ne = 1'b1;
        c.alu_ctrl  = ALU_SUB;
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_ctrl  = ALU_ADD;
      end
      default: c = CTRL_NOP;
    endcase
  end

  assign reg_write_o  = c.reg_write;
  assign mem_to_reg_o = c.mem_to_reg;
  assign mem_write_o  = c.mem_write;
  assign alu_src_o    = c.alu_src;
  assign reg_dst_o    = c.reg_dst;
  assign branch_o     = c.branch;
  assign branch_ne_o  = c.branch_ne;
  assign alu_ctrl_o   = c.alu_ctrl;

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, register file with WB bypass, control decode
// and early beq/bne resolution feeding the fetch PC mux.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int NREG   = 32,
  parameter bit RF_RST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] InstrF,
  input  logic [31:0] PCPlus4F,
  input  logic        StallD,
  input  logic        ForwardAD,
  input  logic        ForwardBD,
  input  logic [31:0] ALUOutM,
  input  logic        RegWriteW,
  input  logic [4:0]  WriteRegW,
  input  logic [31:0] ResultW,
  output logic        PCSrcD,
  output logic [31:0] PCBranchD,
  output logic [31:0] RD1D,
  output logic [31:0] RD2D,
  output logic [4:0]  RsD,
  output logic [4:0]  RtD,
  output logic [4:0]  RdD,
  output logic [31:0] SignImmD,
  output logic        RegWriteD,
  output logic        MemtoRegD,
  output logic        MemWriteD,
  output logic        ALUSrcD,
  output logic        RegDstD,
  output logic        BranchD,
  output logic [2:0]  ALUControlD
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] rf_q [NREG];
  logic        branch_ne;
  logic [31:0] cmp_a, cmp_b;

  assign RsD       = instr_q[25:21];
  assign RtD       = instr_q[20:16];
  assign RdD       = instr_q[15:11];
  assign SignImmD  = sign_ext16(instr_q[15:0]);
  assign PCBranchD = pc4_q + {SignImmD[29:0], 2'b00};

  id_ctrl u_ctrl (
    .op_i         (instr_q[31:26]),
    .funct_i      (instr_q[5:0]),
    .reg_write_o  (RegWriteD),
    .mem_to_reg_o (MemtoRegD),
    .mem_write_o  (MemWriteD),
    .alu_src_o    (ALUSrcD),
    .reg_dst_o    (RegDstD),
    .branch_o     (BranchD),
    .branch_ne_o  (branch_ne),
    .alu_ctrl_o   (ALUControlD)
  );

  // r0 is forced to zero on read so an unreset array never leaks into it.
  always_comb begin
    if (RsD == 5'd0)                             RD1D = '0;
    else if (RegWriteW && (WriteRegW == RsD))    RD1D = ResultW;
    else                                         RD1D = rf_q[RsD];
  end

  always_comb begin
    if (RtD == 5'd0)                             RD2D = '0;
    else if (RegWriteW && (WriteRegW == RtD))    RD2D = ResultW;
    else                                         RD2D = rf_q[RtD];
  end

  assign cmp_a  = ForwardAD ? ALUOutM : RD1D;
  assign cmp_b  = ForwardBD ? ALUOutM : RD2D;
  assign PCSrcD = BranchD & (branch_ne ? (cmp_a != cmp_b) : (cmp_a == cmp_b));

  // Stall outranks the squash of the slot behind a taken branch.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (!StallD) begin
      if (PCSrcD) begin
        instr_d = NOP;
        pc4_d   = '0;
      end else begin
        instr_d = InstrF;
        pc4_d   = PCPlus4F;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q <= NOP;
      pc4_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (RF_RST) begin
        for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end
    end else if (RegWriteW && (WriteRegW != 5'd0)) begin
      rf_q[WriteRegW] <= ResultW;
    end
  end

endmodule
